// File: rtl/uart_top.sv
// uart_top: UART command endpoint. Receives 4-byte packets (0x55, CMD, DATA, CHK),
// verifies CHK == CMD + DATA (mod 256) and applies WRITE/READ to reg_file.
// Optional feature macro: UART_ACK_EN (ACK 0x06 after a good WRITE, NAK 0x15 after
// a bad checksum). With the macro undefined only READ responses are transmitted.
module uart_top #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic uart_tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_HDR, GET_CMD, GET_DATA, GET_CHK, EXEC} p_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done, rx_ferr;

    p_state_t    p_state_q, p_state_d;
    logic [7:0]  cmd_q, cmd_d, data_q, data_d, chk_q, chk_d;
    logic [7:0]  reg_file, reg_file_d;
    logic [7:0]  sum;
    logic        tx_start;
    logic [7:0]  tx_byte;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX deserializer: start re-check at half bit, data and stop at bit centres
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_s2_q && rx_prev_q) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_state_d = R_IDLE;
                    rx_done    = rx_s2_q;
                    rx_ferr    = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Packet parser and command execution
    always_comb begin
        p_state_d  = p_state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        chk_d      = chk_q;
        reg_file_d = reg_file;
        tx_start   = 1'b0;
        tx_byte    = reg_file;
        sum        = cmd_q + data_q;
        case (p_state_q)
            WAIT_HDR: if (rx_done && rx_shift_q == 8'h55) p_state_d = GET_CMD;
            GET_CMD: begin
                if (rx_done) begin
                    cmd_d     = rx_shift_q;
                    p_state_d = GET_DATA;
                end else if (rx_ferr) p_state_d = WAIT_HDR;
            end
            GET_DATA: begin
                if (rx_done) begin
                    data_d    = rx_shift_q;
                    p_state_d = GET_CHK;
                end else if (rx_ferr) p_state_d = WAIT_HDR;
            end
            GET_CHK: begin
                if (rx_done) begin
                    chk_d     = rx_shift_q;
                    p_state_d = EXEC;
                end else if (rx_ferr) p_state_d = WAIT_HDR;
            end
            EXEC: begin
                p_state_d = WAIT_HDR;
                if (sum == chk_q) begin
                    if (cmd_q == 8'h01) begin
                        reg_file_d = data_q;
`ifdef UART_ACK_EN
                        tx_start   = 1'b1;
                        tx_byte    = 8'h06;
`endif
                    end else if (cmd_q == 8'h02) begin
                        tx_start = 1'b1;
                        tx_byte  = reg_file;
                    end
                end else begin
`ifdef UART_ACK_EN
                    tx_start = 1'b1;
                    tx_byte  = 8'h15;
`else
                    tx_start = 1'b0;
`endif
                end
            end
            default: p_state_d = WAIT_HDR;
        endcase
    end

    // TX serializer: requests are only taken while idle, otherwise dropped
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            T_IDLE: begin
                tx_line_d = 1'b1;
                if (tx_start) begin
                    tx_shift_d = tx_byte;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = T_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = T_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            T_STOP: begin
                if (tx_cnt_q == BIT_END) tx_state_d = T_IDLE;
                else tx_cnt_d = tx_cnt_q + 16'd1;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // State registers for RX, parser and TX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            p_state_q  <= WAIT_HDR;
            cmd_q      <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            reg_file   <= 8'h00;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            p_state_q  <= p_state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            reg_file   <= reg_file_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign uart_tx = tx_line_q;

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: expected TX bytes are queued at stimulus time and
// a monitor decodes every frame seen on uart_tx and compares it.
module tb_uart_top;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;   // 16 clocks per bit

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic uart_tx;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%02h required=%02h", name, act, req);
        end else begin
            $display("ok   %s got=%02h", name, act);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] k);
        send_byte(h, 1'b1); idle_bits(1);
        send_byte(c, 1'b1); idle_bits(1);
        send_byte(d, 1'b1); idle_bits(1);
        send_byte(k, 1'b1); idle_bits(1);
    endtask

    // Monitor: decode each 8N1 frame on uart_tx and score it against the queue
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic       stop;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            stop = uart_tx;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got=%02h required=no_frame", b);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin
                    errors++;
                    $display("FAIL tx_data got=%02h required=%02h", b, e);
                end else begin
                    $display("ok   tx_data got=%02h", b);
                end
            end
            checks++;
            if (stop !== 1'b1) begin
                errors++;
                $display("FAIL tx_stop got=%0b required=1", stop);
            end else begin
                $display("ok   tx_stop got=1");
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tx", {7'd0, uart_tx}, 8'h01);
        check("reset_reg", dut.reg_file, 8'h00);
        rst_n = 1'b1;
        idle_bits(2);

        // Valid WRITE
`ifdef UART_ACK_EN
        exp_q.push_back(8'h06);
`endif
        send_pkt(8'h55, 8'h01, 8'hA5, 8'hA6);
        idle_bits(20);
        check("write_a5", dut.reg_file, 8'hA5);

        // Bad checksum is discarded
`ifdef UART_ACK_EN
        exp_q.push_back(8'h15);
`endif
        send_pkt(8'h55, 8'h01, 8'hBB, 8'h00);
        idle_bits(20);
        check("badchk_keep", dut.reg_file, 8'hA5);

        // READ returns the register
        exp_q.push_back(8'hA5);
        send_pkt(8'h55, 8'h02, 8'h00, 8'h02);
        idle_bits(20);
        check("read_keep", dut.reg_file, 8'hA5);

        // Leading garbage byte before the header
`ifdef UART_ACK_EN
        exp_q.push_back(8'h06);
`endif
        send_byte(8'h12, 1'b1); idle_bits(1);
        send_pkt(8'h55, 8'h01, 8'h3C, 8'h3D);
        idle_bits(20);
        check("garbage_write", dut.reg_file, 8'h3C);

        // Reset in the middle of the DATA byte
        send_byte(8'h55, 1'b1); idle_bits(1);
        send_byte(8'h01, 1'b1); idle_bits(1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h77 >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_reg", dut.reg_file, 8'h00);
        check("midreset_tx", {7'd0, uart_tx}, 8'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
`ifdef UART_ACK_EN
        exp_q.push_back(8'h06);
`endif
        send_pkt(8'h55, 8'h01, 8'h5A, 8'h5B);
        idle_bits(20);
        check("after_reset_write", dut.reg_file, 8'h5A);

        // Header with a framing error, then what would otherwise be a valid body
        send_byte(8'h55, 1'b0);
        idle_bits(2);
        send_byte(8'h01, 1'b1); idle_bits(1);
        send_byte(8'h99, 1'b1); idle_bits(1);
        send_byte(8'h9A, 1'b1); idle_bits(1);
        idle_bits(20);
        check("framing_reject", dut.reg_file, 8'h5A);

        // READ after recovery returns the new value
        exp_q.push_back(8'h5A);
        send_pkt(8'h55, 8'h02, 8'h11, 8'h13);
        idle_bits(20);
        check("read_keep2", dut.reg_file, 8'h5A);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL tx_missing got=%0d_pending required=0", exp_q.size());
        end else begin
            $display("ok   tx_missing got=0_pending");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
